// File: rtl/pdm_pkg.sv
// pdm_pkg: constants and helpers shared by the PDM transmitter, the PDM
// receiver and its CIC filter.
package pdm_pkg;

  localparam int PCM_W_DEF = 16;
  localparam int ACC_W     = PCM_W_DEF + 4;
  localparam int DIV_MIN   = 2;
  localparam logic signed [31:0] FS = 32'sd1 <<< (PCM_W_DEF - 1);

  // Symmetric clamp to +/-(2^(acc_w-1)-1) so an accumulator never wraps.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v,
                                             input int acc_w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pdm_tx_sd2_if.sv
// pdm_tx_sd2_if: valid/ready PCM sample stream into the PDM transmitter.
interface pdm_tx_sd2_if
  import pdm_pkg::*;
#(
  parameter int PCM_W = PCM_W_DEF
);
  logic [PCM_W-1:0] pcm_data;
  logic             pcm_valid;
  logic             pcm_ready;

  modport master (output pcm_data, output pcm_valid, input pcm_ready);
  modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_sample_fifo.sv
// pdm_sample_fifo: small synchronous FIFO. The caller gates push with !full
// and pop with !empty; the head is read combinationally.
module pdm_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_data = mem[rd_ptr];
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);

  // Sample storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop keep the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/pdm_tx_sd2.sv
// pdm_tx_sd2: PCM-to-PDM transmitter. Buffers PCM samples, divides clk down
// to the PDM bit clock and runs a 2nd-order 1-bit sigma-delta modulator that
// updates pdm_dat on the pdm_clk falling edge.
module pdm_tx_sd2
  import pdm_pkg::*;
#(
  parameter int PCM_W      = PCM_W_DEF,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [DIV_W-1:0]                clk_div,
  input  logic [7:0]                      osr,
  pdm_tx_sd2_if.slave                     pcm,
  input  logic                            underflow_clr,
  output logic                            pdm_clk,
  output logic                            pdm_dat,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underflow,
  output logic                            irq
);
  localparam int ACC_BITS = PCM_W + 4;
  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [31:0] FS_V = 32'sd1 <<< (PCM_W - 1);

  logic [DIV_W-1:0]           phase, p_cur, p_eff, p_use, half;
  logic                       wrap, strobe, fetch, pop, push;
  logic [7:0]                 bit_cnt, osr_cur, osr_use;
  logic signed [PCM_W-1:0]    cur_sample, x_sel;
  logic signed [ACC_BITS-1:0] i1, i2, i1_n, i2_n;
  logic signed [31:0]         x_ext, fb;
  logic                       y, y_n;
  logic [PCM_W-1:0]           head;
  logic                       fifo_full, fifo_empty;

  pdm_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PCM_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (pcm.pcm_data),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pcm.pcm_ready = !fifo_full;
  assign pdm_dat       = y;
  assign irq           = en && (fifo_level <= LVL_W'(FIFO_DEPTH / 2));

  // Divider and bit-strobe decode. P and OSR are re-sampled only at the start
  // of a period / sample so a mid-run change cannot shorten a half period.
  always_comb begin
    p_eff   = (clk_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : clk_div;
    p_use   = (phase == '0) ? p_eff : p_cur;
    half    = p_use >> 1;
    wrap    = (phase >= p_use - DIV_W'(1));
    strobe  = en && (phase == half - DIV_W'(1));
    osr_use = (bit_cnt == 8'd0) ? osr : osr_cur;
    fetch   = strobe && (bit_cnt == 8'd0);
    pop     = fetch && !fifo_empty;
    push    = pcm.pcm_valid && !fifo_full;
  end

  // Modulator next state: the freshly fetched sample is used on its own strobe.
  always_comb begin
    x_sel = pop ? signed'(head) : cur_sample;
    x_ext = 32'(x_sel);
    fb    = y ? FS_V : -FS_V;
    i1_n  = ACC_BITS'(sat(32'(i1) + x_ext - fb, ACC_BITS));
    i2_n  = ACC_BITS'(sat(32'(i2) + 32'(i1_n) - fb, ACC_BITS));
    y_n   = ~i2_n[ACC_BITS-1];
  end

  // PDM clock generation; pdm_clk is aligned with phase (high for phase < P/2).
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      phase   <= '0;
      p_cur   <= DIV_W'(DIV_MIN);
      pdm_clk <= 1'b0;
    end else begin
      p_cur <= p_use;
      if (wrap) begin
        phase   <= '0;
        pdm_clk <= 1'b1;
      end else begin
        phase   <= phase + DIV_W'(1);
        pdm_clk <= ((phase + DIV_W'(1)) < half);
      end
    end
  end

  // Per-strobe bit counter, sample fetch and integrators.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      osr_cur    <= '0;
      cur_sample <= '0;
      i1         <= '0;
      i2         <= '0;
      y          <= 1'b0;
    end else if (!en) begin
      bit_cnt <= '0;
      i1      <= '0;
      i2      <= '0;
      y       <= 1'b0;
    end else if (strobe) begin
      osr_cur <= osr_use;
      bit_cnt <= (bit_cnt == osr_use - 8'd1) ? 8'd0 : bit_cnt + 8'd1;
      if (pop) cur_sample <= signed'(head);
      i1 <= i1_n;
      i2 <= i2_n;
      y  <= y_n;
    end
  end

  // Sticky underflow; a new underflow wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                       underflow <= 1'b0;
    else if (fetch && fifo_empty)  underflow <= 1'b1;
    else if (underflow_clr)        underflow <= 1'b0;
  end
endmodule

// File: tb/tb_pdm_tx_sd2.sv
// tb_pdm_tx_sd2: directed checks of the PDM transmitter.
module tb_pdm_tx_sd2;
  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] clk_div;
  logic [7:0] osr;
  logic       underflow_clr;
  logic       pdm_clk;
  logic       pdm_dat;
  logic [2:0] fifo_level;
  logic       underflow;
  logic       irq;

  int errors = 0;
  int checks = 0;
  logic prev_clk = 1'b0;

  pdm_tx_sd2_if #(.PCM_W(16)) pif ();

  pdm_tx_sd2 #(.PCM_W(16), .DIV_W(8), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .clk_div       (clk_div),
    .osr           (osr),
    .pcm           (pif),
    .underflow_clr (underflow_clr),
    .pdm_clk       (pdm_clk),
    .pdm_dat       (pdm_dat),
    .fifo_level    (fifo_level),
    .underflow     (underflow),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        valid;
    logic [15:0] data;
    int          level;
    logic        ready;
    logic        irq;
    logic        pclk;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    prev_clk = pdm_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_fall(input string nm, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (prev_clk && !pdm_clk) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no pdm_clk fall expected one within 400 cycles", nm);
    end
  endtask

  task automatic measure(input string nm, input int exp_hi, input int exp_lo);
    int n, hi, lo;
    n = 0;
    while (pdm_clk !== 1'b0 && n < 100) begin step(); n++; end
    while (pdm_clk !== 1'b1 && n < 100) begin step(); n++; end
    hi = 0;
    while (pdm_clk === 1'b1 && n < 100) begin hi++; step(); n++; end
    lo = 0;
    while (pdm_clk === 1'b0 && n < 100) begin lo++; step(); n++; end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s: got no full pdm_clk period expected one within 100 cycles", nm);
    end else begin
      chk($sformatf("%s_high", nm), hi, exp_hi);
      chk($sformatf("%s_low", nm), lo, exp_lo);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ones, changes, n;
    logic prev_dat;
    int vals[3];
    int lo_b[3];
    int hi_b[3];

    rst = 1'b1; en = 1'b0; clk_div = 8'd8; osr = 8'd4; underflow_clr = 1'b0;
    pif.pcm_valid = 1'b0; pif.pcm_data = '0;

    // rst en valid data level ready irq pdm_clk
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h1111, 1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h2222, 2, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h3333, 3, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h4444, 4, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 16'h5555, 4, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 1'b0, 1'b0, 1'b1};

    step();
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; en = tbl[i].en;
      pif.pcm_valid = tbl[i].valid; pif.pcm_data = tbl[i].data;
      step();
      chk($sformatf("vec%0d_level", i), int'(fifo_level), tbl[i].level);
      chk($sformatf("vec%0d_ready", i), int'(pif.pcm_ready), int'(tbl[i].ready));
      chk($sformatf("vec%0d_irq", i), int'(irq), int'(tbl[i].irq));
      chk($sformatf("vec%0d_pdm_clk", i), int'(pdm_clk), int'(tbl[i].pclk));
      chk($sformatf("vec%0d_pdm_dat", i), int'(pdm_dat), 0);
      chk($sformatf("vec%0d_underflow", i), int'(underflow), 0);
    end
    rst = 1'b0; pif.pcm_valid = 1'b0;

    // pdm_dat may only move on the cycle pdm_clk has just fallen
    changes = 0;
    for (int c = 0; c < 64; c++) begin
      prev_dat = pdm_dat;
      step();
      if (pdm_dat !== prev_dat) begin
        changes++;
        chk("dat_on_fall", int'(prev_clk && !pdm_clk), 1);
      end
    end
    chk_range("dat_changes", changes, 1, 64);
    measure("div8", 4, 4);
    clk_div = 8'd1;
    repeat (20) step();
    measure("div1", 1, 1);

    // DC density for three stream values, OSR 64, P=2
    vals[0] = 0;      lo_b[0] = 508; hi_b[0] = 516;
    vals[1] = 16384;  lo_b[1] = 758; hi_b[1] = 778;
    vals[2] = -16384; lo_b[2] = 246; hi_b[2] = 266;
    for (int k = 0; k < 3; k++) begin
      rst = 1'b1; en = 1'b0; pif.pcm_valid = 1'b0;
      step();
      rst = 1'b0; clk_div = 8'd2; osr = 8'd64;
      pif.pcm_data = 16'(vals[k]); pif.pcm_valid = 1'b1;
      repeat (5) step();
      en = 1'b1;
      ones = 0; ok = 1'b1;
      for (int b = 0; b < 64 + 1024; b++) begin
        wait_fall("density_fall", ok);
        if (!ok) break;
        if (b >= 64 && pdm_dat) ones++;
      end
      chk_range($sformatf("density_%0d", vals[k]), ones, lo_b[k], hi_b[k]);
      en = 1'b0; pif.pcm_valid = 1'b0;
    end

    // OSR 4, two prefilled samples, no further pushes
    rst = 1'b1; step(); rst = 1'b0;
    clk_div = 8'd4; osr = 8'd4;
    pif.pcm_valid = 1'b1; pif.pcm_data = 16'h0100; step();
    pif.pcm_data = 16'h0200; step();
    pif.pcm_valid = 1'b0;
    chk("prefill_level", int'(fifo_level), 2);
    en = 1'b1;
    for (int f = 0; f <= 8; f++) begin
      wait_fall("t4_fall", ok);
      if (!ok) break;
      if (f == 0) begin
        chk("t4_pop0_level", int'(fifo_level), 1);
        chk("t4_pop0_uf", int'(underflow), 0);
      end
      if (f == 3) chk("t4_hold_level", int'(fifo_level), 1);
      if (f == 4) begin
        chk("t4_pop4_level", int'(fifo_level), 0);
        chk("t4_pop4_uf", int'(underflow), 0);
      end
      if (f == 7) chk("t4_pre_uf", int'(underflow), 0);
      if (f == 8) begin
        chk("t4_uf_set", int'(underflow), 1);
        chk("t4_held_sample", int'(dut.cur_sample), 512);
      end
    end
    underflow_clr = 1'b1;
    step();
    chk("t4_clr", int'(underflow), 0);
    for (int f = 9; f <= 12; f++) begin
      wait_fall("t4_fall_b", ok);
      if (!ok) break;
    end
    chk("t4_set_beats_clr", int'(underflow), 1);
    step();
    chk("t4_clr_again", int'(underflow), 0);
    underflow_clr = 1'b0;

    // Full FIFO with a push offered across the first pop
    en = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    pif.pcm_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pif.pcm_data = 16'(32'h0800 + i);
      step();
    end
    chk("t5_full_level", int'(fifo_level), 4);
    chk("t5_full_ready", int'(pif.pcm_ready), 0);
    pif.pcm_data = 16'h7777;
    en = 1'b1;
    for (int f = 0; f <= 4; f++) begin
      wait_fall("t5_fall", ok);
      if (!ok) break;
      if (f == 0) begin
        pif.pcm_valid = 1'b0;
        chk("t5_refused_level", int'(fifo_level), 3);
        chk("t5_irq_at3", int'(irq), 0);
      end
      if (f == 3) chk("t5_irq_still3", int'(irq), 0);
      if (f == 4) begin
        chk("t5_level2", int'(fifo_level), 2);
        chk("t5_irq_at2", int'(irq), 1);
      end
    end

    // Mid-stream reset
    n = 0;
    while (!underflow && n < 200) begin step(); n++; end
    chk("t6_uf_before", int'(underflow), 1);
    rst = 1'b1;
    step();
    chk("t6_level", int'(fifo_level), 0);
    chk("t6_pdm_clk", int'(pdm_clk), 0);
    chk("t6_pdm_dat", int'(pdm_dat), 0);
    chk("t6_uf", int'(underflow), 0);
    chk("t6_i1", int'(dut.i1), 0);
    chk("t6_i2", int'(dut.i2), 0);
    chk("t6_ready", int'(pif.pcm_ready), 1);
    rst = 1'b0;
    wait_fall("t6_fall", ok);
    if (ok) begin
      chk("t6_uf_first_fetch", int'(underflow), 1);
      chk("t6_level_after", int'(fifo_level), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
